// File: rtl/array_param.sv
// Parameterised byte-enabled register array with a clear-sweep controller.
// After reset (or on a clear request) every entry is written with INIT_VAL,
// one entry per cycle, while busy is high and user accesses are ignored.
// Reads are registered (write-first, 1-cycle latency) or combinational.
module array_param #(
  parameter int              WIDTH    = 16,
  parameter int              DEPTH    = 4,
  parameter int              ADDR     = 2,
  parameter int              REG_READ = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   write_data,
  input  logic [ADDR-1:0]    write_addr,
  input  logic               write_en,
  input  logic [WIDTH/8-1:0] write_be,
  input  logic [ADDR-1:0]    read_addr,
  input  logic               read_en,
  output logic [WIDTH-1:0]   read_data,
  output logic               read_valid,
  input  logic               clear,
  output logic               busy
);

  localparam int NB = WIDTH / 8;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state, state_next;
  logic [ADDR-1:0] cnt, cnt_next;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_in_range, rd_in_range;
  logic [ADDR-1:0]  wr_idx, rd_idx;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_word;

  // Out-of-range addresses are redirected to entry 0 for indexing only;
  // the in-range flags keep them from having any effect.
  assign wr_in_range = int'(write_addr) < DEPTH;
  assign rd_in_range = int'(read_addr) < DEPTH;
  assign wr_idx      = wr_in_range ? write_addr : '0;
  assign rd_idx      = rd_in_range ? read_addr  : '0;

  // A user write is accepted only in IDLE, in range, and when clear does not win.
  assign wr_ok = (state == IDLE) && write_en && !clear && wr_in_range;
  assign rd_ok = (state == IDLE) && read_en;

  // State register and sweep counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: sweep DEPTH entries, then idle until clear.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == ADDR'(DEPTH - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // Controller outputs.
  always_comb begin
    busy = (state == CLEAR);
  end

  // Byte-enable merge of the write word into the currently stored entry.
  always_comb begin
    wr_merged = mem[wr_idx];
    for (int unsigned k = 0; k < NB; k++) begin
      if (write_be[k]) wr_merged[8*k +: 8] = write_data[8*k +: 8];
    end
  end

  // Storage: sweep writes INIT_VAL, otherwise accepted user writes.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= INIT_VAL;
    end else if (wr_ok) begin
      mem[wr_idx] <= wr_merged;
    end
  end

  // Raw read word; out-of-range addresses read as zero.
  always_comb begin
    rd_word = rd_in_range ? mem[rd_idx] : '0;
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [WIDTH-1:0] rd_fwd;

      // Write-first: a same-cycle write to the read address is forwarded
      // already merged, since the array itself only updates at the edge.
      always_comb begin
        rd_fwd = (wr_ok && (write_addr == read_addr)) ? wr_merged : rd_word;
      end

      // Registered read port; data holds when no read is accepted.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          read_valid <= 1'b0;
          read_data  <= '0;
        end else begin
          read_valid <= rd_ok;
          if (rd_ok) read_data <= rd_fwd;
        end
      end
    end else begin : g_comb_read
      // Combinational read port.
      always_comb begin
        read_data  = rd_word;
        read_valid = rd_ok;
      end
    end
  endgenerate

endmodule

// File: doc/array_param.md
ARRAY_PARAM -- requirements
Module: array_param

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 4, number of entries; need not be a power of two.
REQ-003 Parameter ADDR, default 2, address width; SHALL satisfy 2**ADDR >= DEPTH.
REQ-004 Parameter REG_READ, default 1; 1 = registered read (1-cycle latency), 0 = combinational read.
REQ-005 Parameter INIT_VAL, default 0, WIDTH-bit value written to every entry by the clear sweep.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 Reset is asynchronous and active-high: rst  input  1  asynchronous, active-high reset.
REQ-008 write_data  input  WIDTH  write word.
REQ-009 write_addr  input  ADDR  write entry index.
REQ-010 write_en  input  1  write request.
REQ-011 write_be  input  WIDTH/8  byte enables; bit k gates write_data[8k+7:8k].
REQ-012 read_addr  input  ADDR  read entry index.
REQ-013 read_en  input  1  read request.
REQ-014 read_data  output  WIDTH  read word.
REQ-015 read_valid  output  1  read_data holds the result of an accepted read.
REQ-016 clear  input  1  request a full-array sweep to INIT_VAL.
REQ-017 busy  output  1  clear sweep in progress; user accesses ignored.

Function
REQ-018 Controller SHALL have two states: CLEAR and IDLE; busy = (state == CLEAR).
REQ-019 In CLEAR, each cycle SHALL write INIT_VAL to entry cnt and increment cnt; after writing entry DEPTH-1, SHALL move to IDLE; sweep takes exactly DEPTH cycles.
REQ-020 In IDLE, clear=1 SHALL enter CLEAR next cycle with cnt=0; clear while busy SHALL be ignored (no restart).
REQ-021 In IDLE, write_en=1 SHALL update, at the rising edge, only the bytes of entry write_addr whose write_be bit is 1; other bytes retain value.
REQ-022 write_en with write_be all zero SHALL leave memory unchanged.
REQ-023 write_en or read_en while busy SHALL be ignored; no memory change, read_valid stays 0.
REQ-024 clear and write_en in the same IDLE cycle: clear wins, write discarded.
REQ-025 write_addr >= DEPTH SHALL be ignored; read_addr >= DEPTH SHALL return 0 with read_valid asserted normally.
REQ-026 REG_READ=1: read_en=1 in IDLE at edge N SHALL present data at read_data and read_valid=1 after edge N; with read_en=0, read_valid=0 and read_data holds its last value.
REQ-027 REG_READ=1, read and write to same address in same cycle: read_data SHALL return the merged new word (write-first, byte-enable applied).
REQ-028 REG_READ=0: read_data SHALL combinationally reflect entry read_addr; read_valid = read_en & ~busy; same-address write appears only after the edge.
REQ-029 Back-to-back reads every cycle SHALL be supported with one result per cycle.

Reset
REQ-030 rst=1 SHALL immediately force state=CLEAR, cnt=0, busy=1, read_valid=0, read_data=0 (REG_READ=1).
REQ-031 Memory contents SHALL NOT be reset directly; first sweep after rst deassertion initialises them.
REQ-032 rst asserted mid-sweep or mid-access SHALL abort it; sweep restarts from entry 0 after deassertion.

Verification
REQ-033 Release rst -> busy=1 for exactly 4 cycles, then 0; reads of addresses 0..3 return 0x0000.
REQ-034 Write 0x1111,0x2222,0x3333,0x4444 to 0..3 (be=2'b11), read 0..3 -> same values, read_valid=1 one cycle after each read_en (REG_READ=1).
REQ-035 Entry 1 = 0x2222, write 0xABCD with be=2'b10 -> reads 0xAB22; same-cycle read of addr 1 returns 0xAB22.
REQ-036 Pulse clear after loading data, attempt write 0x5555 to addr 2 during busy -> busy 4 cycles, all entries read INIT_VAL, write discarded.
REQ-037 Assert rst for 1 cycle at sweep cycle 2 -> busy remains 1, sweep restarts, busy falls 4 cycles after rst release.
REQ-038 REG_READ=0, DEPTH=3: read addr 3 -> read_data=0, read_valid=1 same cycle; write addr 3 -> no entry changes.
